icache_ctrl_sequencer: RTL and testbench
========================================

Name: icache_ctrl_sequencer

Overview:
- Parametrised multi-bank successor to the private/shared/multi-port icache control-unit buses.
- Takes one master-side control channel (bypass, full flush, selective flush) and fans it out to NB_BANKS cache banks under a per-command bank mask.
- Collects per-bank acknowledges, with a timeout, and returns a single master acknowledge.
- Also hosts per-bank and global saturating statistics counters. Sits between the cluster control-register block and the banked icache.

Parameters:
- NB_BANKS, 4, number of cache banks served (1..32).
- ADDR_W, 32, selective-flush address width.
- CNT_W, 32, statistics counter width.
- TIMEOUT_CYC, 1024, maximum wait cycles for bank acknowledges; 0 disables the timeout.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- bank_mask_i  in  NB_BANKS  banks taking part in the next command; sampled at command accept.
- bypass_req_i  in  1  requested mode, level (1 = bypass).
- bypass_ack_o  out  1  completed mode, level.
- flush_req_i  in  1  full-flush request; held high until flush_ack_o.
- flush_ack_o  out  1  full-flush done, 1-cycle pulse.
- sel_flush_req_i  in  1  selective-flush request; held high until sel_flush_ack_o.
- sel_flush_addr_i  in  ADDR_W  selective-flush address.
- sel_flush_ack_o  out  1  selective-flush done, 1-cycle pulse.
- err_o  out  1  pulse, coincident with an ack, when that command timed out.
- bank_bypass_req_o  out  NB_BANKS  per-bank bypass level.
- bank_bypass_ack_i  in  NB_BANKS  per-bank bypass status level.
- bank_flush_req_o  out  NB_BANKS  per-bank flush request.
- bank_flush_ack_i  in  NB_BANKS  per-bank flush ack pulse.
- bank_sel_flush_req_o  out  NB_BANKS  per-bank selective-flush request.
- bank_sel_flush_addr_o  out  ADDR_W  registered selective-flush address.
- bank_sel_flush_ack_i  in  NB_BANKS  per-bank selective-flush ack pulse.
- bank_evt_i  in  NB_BANKS x 4  event pulses per bank, indexed HIT/TRANS/MISS/CONG.
- ctrl_enable_regs_i  in  1  counting enable.
- ctrl_clear_regs_i  in  1  synchronous clear of all counters.
- bank_count_o  out  NB_BANKS x 4 x CNT_W  per-bank counters.
- global_count_o  out  4 x CNT_W  global counters.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, mode register 0, counters 0, pending mask 0.
- FSM states:
  - IDLE: accepts one command per cycle. Priority is flush > sel_flush > bypass change (bypass_req_i != mode register). On accept, latch mask_q = bank_mask_i, pend_q = mask_q, load the timeout counter, and latch the address for sel_flush.
  - FLUSH_WAIT: bank_flush_req_o = pend_q. An ack on bank i clears pend_q[i], so that request drops the next cycle. Acks from banks not pending are ignored.
  - SEL_WAIT: same as FLUSH_WAIT on the sel channels. bank_sel_flush_addr_o is stable for the whole command.
  - BYP_WAIT: bank_bypass_req_o[i] = target mode for masked banks; unmasked banks keep their previous value. Completes when bank_bypass_ack_i equals the target on every masked bank.
  - Completion: pend_q == 0 or the match condition holds. Flush/sel: pulse the ack, go to RELEASE. Bypass: update mode register and bypass_ack_o, go to IDLE.
  - RELEASE: wait for the serviced request to go low, then go to IDLE. This prevents a held request from re-triggering.
- Latency: empty mask → ack 1 cycle after accept. Otherwise ack 1 cycle after the last bank ack is registered.
- Timeout (TIMEOUT_CYC > 0): the counter decrements each WAIT cycle. At 0, force completion: ack + err_o in the same cycle, all bank requests dropped, mode register still updated for bypass.
- A bypass change arriving during a flush is deferred until IDLE. A bypass request that toggles back before acceptance is a no-op.
- bank_mask_i changes mid-command have no effect.
- Counters:
  - Per-bank: +1 per event pulse when enabled, saturating at 2^CNT_W-1.
  - Global: + popcount of that event across banks, saturating.
  - Clear has priority over increment in the same cycle.
  - Outputs are registered, 1-cycle latency from event.
- Async reset mid-command aborts it: all requests drop immediately and no ack is issued.

Decomposition:
- Package icache_ctrl_pkg:
  - Event index enum: EVT_HIT=0, EVT_TRANS=1, EVT_MISS=2, EVT_CONG=3, N_EVT=4.
  - FSM state enum.
  - Saturating-add function.
- One sub-module, icache_stat_counters: per-bank and global counter array; parameters NB_BANKS and CNT_W.

Test Plan:
- Flush, mask=4'b1111, banks ack at cycles 3/5/5/9 → bank requests drop individually; flush_ack_o pulses once 1 cycle after bank 3's ack; err_o=0; FSM in RELEASE until flush_req_i low.
- Sel flush, addr=0x1C000040, mask=4'b0010 → only bank_sel_flush_req_o[1] asserts; address stable until ack; other banks idle.
- bypass_req_i 0→1, mask=4'b1111, bank 2 status rises last → bypass_ack_o rises 1 cycle after bank 2 matches. Then mask=0, bypass 1→0 → ack 1 cycle later, bank requests unchanged.
- TIMEOUT_CYC=16, flush with bank 0 never acking → at cycle 16, flush_ack_o and err_o pulse together and bank_flush_req_o goes to 0.
- Flush and bypass change in the same cycle → flush is serviced first; bypass starts only after RELEASE.
- CNT_W=4: 20 HIT pulses on bank 1 → bank count saturates at 15. HIT on all 4 banks for 2 cycles → global count 8. Clear together with an event → 0.

Source files
------------

// File: rtl/icache_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : icache_ctrl_pkg
// Brief    : Shared types and helpers for the banked icache control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package icache_ctrl_pkg;

    typedef enum logic [1:0] {
        EVT_HIT   = 2'd0,
        EVT_TRANS = 2'd1,
        EVT_MISS  = 2'd2,
        EVT_CONG  = 2'd3
    } evt_e;

    localparam int N_EVT = 4;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_FLUSH_WAIT = 3'd1,
        ST_SEL_WAIT   = 3'd2,
        ST_BYP_WAIT   = 3'd3,
        ST_RELEASE    = 3'd4
    } state_e;

    // Counters narrower than SAT_W are zero-extended by the caller.
    localparam int SAT_W = 64;

    function automatic logic [SAT_W-1:0] sat_add(input logic [SAT_W-1:0] a,
                                                 input logic [SAT_W-1:0] b,
                                                 input logic [SAT_W-1:0] lim);
        logic [SAT_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        if (sum > {1'b0, lim}) begin
            return lim;
        end
        return sum[SAT_W-1:0];
    endfunction

endpackage
`default_nettype wire

// File: rtl/icache_stat_counters.sv
`default_nettype none
// ============================================================================
// Module   : icache_stat_counters
// Brief    : Per-bank and global saturating event counters.
// Revision : 1.0 - initial release
// ============================================================================
module icache_stat_counters
    import icache_ctrl_pkg::*;
#(
    parameter int NB_BANKS = 4,
    parameter int CNT_W    = 32
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            enable_i,
    input  logic                            clear_i,
    input  logic [NB_BANKS*N_EVT-1:0]       evt_i,
    output logic [NB_BANKS*N_EVT*CNT_W-1:0] bank_count_o,
    output logic [N_EVT*CNT_W-1:0]          global_count_o
);

    localparam int N_CNT = NB_BANKS * N_EVT;
    localparam int POP_W = $clog2(NB_BANKS + 1);
    localparam logic [SAT_W-1:0] C_CNT_MAX = SAT_W'({CNT_W{1'b1}});

    logic [CNT_W-1:0] bank_cnt_q [N_CNT];
    logic [CNT_W-1:0] bank_cnt_d [N_CNT];
    logic [CNT_W-1:0] glob_cnt_q [N_EVT];
    logic [CNT_W-1:0] glob_cnt_d [N_EVT];
    logic [POP_W-1:0] evt_pop    [N_EVT];

    always_comb begin
        for (int e = 0; e < N_EVT; e++) begin
            evt_pop[e] = '0;
            for (int b = 0; b < NB_BANKS; b++) begin
                evt_pop[e] = evt_pop[e] + POP_W'(evt_i[b*N_EVT+e]);
            end
        end
        for (int i = 0; i < N_CNT; i++) begin
            bank_cnt_d[i] = bank_cnt_q[i];
            if (clear_i) begin
                bank_cnt_d[i] = '0;
            end else if (enable_i && evt_i[i]) begin
                bank_cnt_d[i] = CNT_W'(sat_add(SAT_W'(bank_cnt_q[i]), SAT_W'(1), C_CNT_MAX));
            end
        end
        for (int e = 0; e < N_EVT; e++) begin
            glob_cnt_d[e] = glob_cnt_q[e];
            if (clear_i) begin
                glob_cnt_d[e] = '0;
            end else if (enable_i) begin
                glob_cnt_d[e] = CNT_W'(sat_add(SAT_W'(glob_cnt_q[e]), SAT_W'(evt_pop[e]), C_CNT_MAX));
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N_CNT; i++) bank_cnt_q[i] <= '0;
            for (int e = 0; e < N_EVT; e++) glob_cnt_q[e] <= '0;
        end else begin
            for (int i = 0; i < N_CNT; i++) bank_cnt_q[i] <= bank_cnt_d[i];
            for (int e = 0; e < N_EVT; e++) glob_cnt_q[e] <= glob_cnt_d[e];
        end
    end

    for (genvar i = 0; i < N_CNT; i++) begin : g_bank_out
        assign bank_count_o[i*CNT_W +: CNT_W] = bank_cnt_q[i];
    end

    for (genvar e = 0; e < N_EVT; e++) begin : g_glob_out
        assign global_count_o[e*CNT_W +: CNT_W] = glob_cnt_q[e];
    end

endmodule
`default_nettype wire

// File: rtl/icache_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : icache_ctrl_sequencer
// Brief    : Fans master bypass/flush commands out to masked banks, merges acks.
// Revision : 1.0 - initial release
// ============================================================================
module icache_ctrl_sequencer
    import icache_ctrl_pkg::*;
#(
    parameter int NB_BANKS    = 4,
    parameter int ADDR_W      = 32,
    parameter int CNT_W       = 32,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic [NB_BANKS-1:0]             bank_mask_i,
    input  logic                            bypass_req_i,
    output logic                            bypass_ack_o,
    input  logic                            flush_req_i,
    output logic                            flush_ack_o,
    input  logic                            sel_flush_req_i,
    input  logic [ADDR_W-1:0]               sel_flush_addr_i,
    output logic                            sel_flush_ack_o,
    output logic                            err_o,
    output logic [NB_BANKS-1:0]             bank_bypass_req_o,
    input  logic [NB_BANKS-1:0]             bank_bypass_ack_i,
    output logic [NB_BANKS-1:0]             bank_flush_req_o,
    input  logic [NB_BANKS-1:0]             bank_flush_ack_i,
    output logic [NB_BANKS-1:0]             bank_sel_flush_req_o,
    output logic [ADDR_W-1:0]               bank_sel_flush_addr_o,
    input  logic [NB_BANKS-1:0]             bank_sel_flush_ack_i,
    input  logic [NB_BANKS*N_EVT-1:0]       bank_evt_i,
    input  logic                            ctrl_enable_regs_i,
    input  logic                            ctrl_clear_regs_i,
    output logic [NB_BANKS*N_EVT*CNT_W-1:0] bank_count_o,
    output logic [N_EVT*CNT_W-1:0]          global_count_o
);

    localparam int TMO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMO_W-1:0] C_TMO_LOAD = TMO_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

    state_e              state_q, state_d;
    logic                mode_q, mode_d;
    logic                tgt_q, tgt_d;
    logic                rel_sel_q, rel_sel_d;
    logic [NB_BANKS-1:0] mask_q, mask_d;
    logic [NB_BANKS-1:0] pend_q, pend_d;
    logic [NB_BANKS-1:0] byp_lvl_q, byp_lvl_d;
    logic [NB_BANKS-1:0] byp_sts_q;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [TMO_W-1:0]    tmo_q, tmo_d;
    logic                in_wait, timeout, done, finish;

    // Bank bypass status is registered so bypass completion follows the same
    // one-cycle-after-registration timing as the flush channels.
    always_comb begin
        in_wait = (state_q == ST_FLUSH_WAIT) || (state_q == ST_SEL_WAIT) ||
                  (state_q == ST_BYP_WAIT);
        timeout = (TIMEOUT_CYC != 0) && in_wait && (tmo_q == '0);
        if (state_q == ST_BYP_WAIT) begin
            done = ((byp_sts_q ^ {NB_BANKS{tgt_q}}) & mask_q) == '0;
        end else begin
            done = (pend_q == '0);
        end
        finish = in_wait && (done || timeout);
    end

    always_comb begin
        state_d   = state_q;
        mode_d    = mode_q;
        tgt_d     = tgt_q;
        rel_sel_d = rel_sel_q;
        mask_d    = mask_q;
        pend_d    = pend_q;
        byp_lvl_d = byp_lvl_q;
        addr_d    = addr_q;
        tmo_d     = tmo_q;
        if (in_wait && (tmo_q != '0)) begin
            tmo_d = tmo_q - TMO_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (flush_req_i || sel_flush_req_i || (bypass_req_i != mode_q)) begin
                    mask_d = bank_mask_i;
                    pend_d = bank_mask_i;
                    tmo_d  = C_TMO_LOAD;
                end
                if (flush_req_i) begin
                    state_d = ST_FLUSH_WAIT;
                end else if (sel_flush_req_i) begin
                    state_d = ST_SEL_WAIT;
                    addr_d  = sel_flush_addr_i;
                end else if (bypass_req_i != mode_q) begin
                    state_d   = ST_BYP_WAIT;
                    tgt_d     = bypass_req_i;
                    byp_lvl_d = (byp_lvl_q & ~bank_mask_i) |
                                (bank_mask_i & {NB_BANKS{bypass_req_i}});
                end
            end
            ST_FLUSH_WAIT, ST_SEL_WAIT: begin
                pend_d = pend_q & ~((state_q == ST_FLUSH_WAIT) ? bank_flush_ack_i
                                                               : bank_sel_flush_ack_i);
                if (finish) begin
                    state_d   = ST_RELEASE;
                    pend_d    = '0;
                    rel_sel_d = (state_q == ST_SEL_WAIT);
                end
            end
            ST_BYP_WAIT: begin
                if (finish) begin
                    state_d = ST_IDLE;
                    mode_d  = tgt_q;
                end
            end
            ST_RELEASE: begin
                if (!(rel_sel_q ? sel_flush_req_i : flush_req_i)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ST_IDLE;
            mode_q    <= 1'b0;
            tgt_q     <= 1'b0;
            rel_sel_q <= 1'b0;
            mask_q    <= '0;
            pend_q    <= '0;
            byp_lvl_q <= '0;
            byp_sts_q <= '0;
            addr_q    <= '0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            tgt_q     <= tgt_d;
            rel_sel_q <= rel_sel_d;
            mask_q    <= mask_d;
            pend_q    <= pend_d;
            byp_lvl_q <= byp_lvl_d;
            byp_sts_q <= bank_bypass_ack_i;
            addr_q    <= addr_d;
            tmo_q     <= tmo_d;
        end
    end

    // A timed-out command drops its bank requests in the same cycle as the ack.
    assign flush_ack_o           = finish && (state_q == ST_FLUSH_WAIT);
    assign sel_flush_ack_o       = finish && (state_q == ST_SEL_WAIT);
    assign err_o                 = timeout && !done;
    assign bypass_ack_o          = (finish && (state_q == ST_BYP_WAIT)) ? tgt_q : mode_q;
    assign bank_flush_req_o      = (state_q == ST_FLUSH_WAIT && !timeout) ? pend_q : '0;
    assign bank_sel_flush_req_o  = (state_q == ST_SEL_WAIT && !timeout) ? pend_q : '0;
    assign bank_bypass_req_o     = byp_lvl_q;
    assign bank_sel_flush_addr_o = addr_q;

    icache_stat_counters #(
        .NB_BANKS (NB_BANKS),
        .CNT_W    (CNT_W)
    ) u_stat_counters (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .enable_i       (ctrl_enable_regs_i),
        .clear_i        (ctrl_clear_regs_i),
        .evt_i          (bank_evt_i),
        .bank_count_o   (bank_count_o),
        .global_count_o (global_count_o)
    );

endmodule
`default_nettype wire

// File: tb/tb_icache_ctrl_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_icache_ctrl_sequencer
// Brief    : Self-checking bench for the icache control sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_icache_ctrl_sequencer;
    import icache_ctrl_pkg::*;

    localparam int NB = 4;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic [NB-1:0]   bank_mask_i;
    logic            bypass_req_i, bypass_ack_o;
    logic            flush_req_i, flush_ack_o;
    logic            sel_flush_req_i, sel_flush_ack_o;
    logic [31:0]     sel_flush_addr_i, bank_sel_flush_addr_o;
    logic            err_o;
    logic [NB-1:0]   bank_bypass_req_o, bank_bypass_ack_i;
    logic [NB-1:0]   bank_flush_req_o, bank_flush_ack_i;
    logic [NB-1:0]   bank_sel_flush_req_o, bank_sel_flush_ack_i;
    logic [NB*4-1:0] bank_evt_i;
    logic            ctrl_enable_regs_i, ctrl_clear_regs_i;
    logic [NB*4*CW-1:0] bank_count_o;
    logic [4*CW-1:0] global_count_o;

    icache_ctrl_sequencer #(
        .NB_BANKS(NB), .ADDR_W(32), .CNT_W(CW), .TIMEOUT_CYC(16)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .bank_mask_i(bank_mask_i),
        .bypass_req_i(bypass_req_i), .bypass_ack_o(bypass_ack_o),
        .flush_req_i(flush_req_i), .flush_ack_o(flush_ack_o),
        .sel_flush_req_i(sel_flush_req_i), .sel_flush_addr_i(sel_flush_addr_i),
        .sel_flush_ack_o(sel_flush_ack_o), .err_o(err_o),
        .bank_bypass_req_o(bank_bypass_req_o), .bank_bypass_ack_i(bank_bypass_ack_i),
        .bank_flush_req_o(bank_flush_req_o), .bank_flush_ack_i(bank_flush_ack_i),
        .bank_sel_flush_req_o(bank_sel_flush_req_o),
        .bank_sel_flush_addr_o(bank_sel_flush_addr_o),
        .bank_sel_flush_ack_i(bank_sel_flush_ack_i), .bank_evt_i(bank_evt_i),
        .ctrl_enable_regs_i(ctrl_enable_regs_i), .ctrl_clear_regs_i(ctrl_clear_regs_i),
        .bank_count_o(bank_count_o), .global_count_o(global_count_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    logic prev_byp = 1'b0;

    // Expected master-side events: 1 = flush ack, 2 = sel ack, 3 = bypass change
    typedef struct packed {logic [1:0] code; logic err; logic [31:0] cyc;} ev_t;
    ev_t sb[$];

    typedef struct packed {logic [63:0] bank; logic [15:0] glob;} cexp_t;
    cexp_t cq[$];

    typedef struct {logic [15:0] evt; logic en; logic clr; int reps; int exp_b1; int exp_g;} crow_t;
    crow_t rows[8];
    int m_b[16];
    int m_g[4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic expect_ev(input logic [1:0] code, input logic err, input int at);
        ev_t e;
        e.code = code;
        e.err  = err;
        e.cyc  = 32'(at);
        sb.push_back(e);
    endtask

    task automatic mon_ev(input logic [1:0] code);
        ev_t e;
        if (sb.size() == 0) begin
            chk("unexpected_ack", 64'(code), 64'd0);
            return;
        end
        e = sb.pop_front();
        chk("ack_kind", 64'(code), 64'(e.code));
        chk("ack_err", 64'(err_o), 64'(e.err));
        chk("ack_cycle", 64'(cyc), 64'(e.cyc));
    endtask

    always @(negedge clk) begin
        if (rst_ni) begin
            if (flush_ack_o) mon_ev(2'd1);
            if (sel_flush_ack_o) mon_ev(2'd2);
            if (bypass_ack_o != prev_byp) mon_ev(2'd3);
        end
        prev_byp = bypass_ack_o;
    end

    task automatic model_step(input logic [15:0] evt, input logic en, input logic clr);
        cexp_t x;
        int cnt;
        if (clr) begin
            for (int i = 0; i < 16; i++) m_b[i] = 0;
            for (int e = 0; e < 4; e++) m_g[e] = 0;
        end else if (en) begin
            for (int e = 0; e < 4; e++) begin
                cnt = 0;
                for (int b = 0; b < 4; b++) begin
                    if (evt[b*4+e]) begin
                        cnt++;
                        m_b[b*4+e] = (m_b[b*4+e] >= 15) ? 15 : m_b[b*4+e] + 1;
                    end
                end
                m_g[e] = (m_g[e] + cnt > 15) ? 15 : m_g[e] + cnt;
            end
        end
        for (int i = 0; i < 16; i++) x.bank[i*4 +: 4] = 4'(m_b[i]);
        for (int e = 0; e < 4; e++) x.glob[e*4 +: 4] = 4'(m_g[e]);
        cq.push_back(x);
    endtask

    initial begin
        int t0;
        int k_fl[4];
        logic [3:0] er;
        cexp_t x;

        rows[0] = '{16'h0000, 1'b1, 1'b1, 1, 0, 0};
        rows[1] = '{16'h0010, 1'b1, 1'b0, 20, 15, 15};
        rows[2] = '{16'h0000, 1'b1, 1'b1, 1, 0, 0};
        rows[3] = '{16'h1111, 1'b1, 1'b0, 2, 2, 8};
        rows[4] = '{16'h1111, 1'b0, 1'b0, 3, 2, 8};
        rows[5] = '{16'h1111, 1'b1, 1'b1, 1, 0, 0};
        rows[6] = '{16'hFFFF, 1'b1, 1'b0, 1, 1, 4};
        rows[7] = '{16'hFFFF, 1'b1, 1'b0, 3, 4, 15};
        for (int i = 0; i < 16; i++) m_b[i] = 0;
        for (int e = 0; e < 4; e++) m_g[e] = 0;

        rst_ni = 1'b0; bank_mask_i = '0; bypass_req_i = 0; flush_req_i = 0;
        sel_flush_req_i = 0; sel_flush_addr_i = '0; bank_bypass_ack_i = '0;
        bank_flush_ack_i = '0; bank_sel_flush_ack_i = '0; bank_evt_i = '0;
        ctrl_enable_regs_i = 1'b1; ctrl_clear_regs_i = 1'b0;
        repeat (3) next_cycle();
        rst_ni = 1'b1;
        @(negedge clk);
        chk("rst_acks", 64'({flush_ack_o, sel_flush_ack_o, bypass_ack_o, err_o}), 64'd0);
        chk("rst_bank_reqs", 64'({bank_flush_req_o, bank_sel_flush_req_o, bank_bypass_req_o}), 64'd0);
        chk("rst_addr", 64'(bank_sel_flush_addr_o), 64'd0);
        chk("rst_counts", bank_count_o | 64'(global_count_o), 64'd0);

        // Full flush, all banks, acks staggered over the wait window
        k_fl = '{3, 5, 5, 9};
        next_cycle();
        t0 = cyc; bank_mask_i = 4'hF; flush_req_i = 1'b1;
        expect_ev(2'd1, 1'b0, t0 + 10);
        for (int n = 1; n <= 12; n++) begin
            next_cycle();
            if (n == 2) bank_mask_i = 4'h0;
            for (int i = 0; i < 4; i++) bank_flush_ack_i[i] = (n == k_fl[i]);
            for (int i = 0; i < 4; i++) er[i] = (n <= k_fl[i]);
            @(negedge clk);
            if (n <= 10) chk("flush_bank_req", 64'(bank_flush_req_o), 64'(er));
            if (n >= 11) chk("flush_release", 64'(dut.state_q), 64'(ST_RELEASE));
        end
        next_cycle(); flush_req_i = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("flush_back_idle", 64'(dut.state_q), 64'(ST_IDLE));

        // Selective flush on bank 1 only; address must hold for the command
        next_cycle();
        t0 = cyc; bank_mask_i = 4'b0010; sel_flush_req_i = 1'b1;
        sel_flush_addr_i = 32'h1C00_0040;
        expect_ev(2'd2, 1'b0, t0 + 5);
        for (int n = 1; n <= 5; n++) begin
            next_cycle();
            if (n == 2) sel_flush_addr_i = 32'hDEAD_BEEF;
            bank_sel_flush_ack_i = (n == 4) ? 4'b0010 : (n == 2) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            chk("sel_bank_req", 64'(bank_sel_flush_req_o), (n <= 4) ? 64'h2 : 64'h0);
            chk("sel_addr", 64'(bank_sel_flush_addr_o), 64'h1C00_0040);
            chk("sel_no_full_flush", 64'(bank_flush_req_o), 64'd0);
        end
        next_cycle(); sel_flush_req_i = 1'b0;
        next_cycle();

        // Bypass on, all banks, bank 2 status rises last
        t0 = cyc; bank_mask_i = 4'hF; bypass_req_i = 1'b1;
        expect_ev(2'd3, 1'b0, t0 + 6);
        for (int n = 1; n <= 6; n++) begin
            next_cycle();
            if (n == 2) bank_bypass_ack_i = 4'b1011;
            if (n == 5) bank_bypass_ack_i = 4'b1111;
            @(negedge clk);
            chk("byp_bank_req", 64'(bank_bypass_req_o), 64'hF);
            if (n == 5) chk("byp_ack_early", 64'(bypass_ack_o), 64'd0);
        end
        // Bypass off with empty mask: per-bank levels untouched
        next_cycle();
        t0 = cyc; bank_mask_i = 4'h0; bypass_req_i = 1'b0;
        expect_ev(2'd3, 1'b0, t0 + 1);
        for (int n = 1; n <= 2; n++) begin
            next_cycle();
            bank_bypass_ack_i = 4'h0;
            @(negedge clk);
            chk("byp_empty_keep", 64'(bank_bypass_req_o), 64'hF);
        end

        // Timeout: bank 0 never answers
        next_cycle();
        t0 = cyc; bank_mask_i = 4'b0001; flush_req_i = 1'b1;
        expect_ev(2'd1, 1'b1, t0 + 16);
        for (int n = 1; n <= 16; n++) begin
            next_cycle();
            @(negedge clk);
            if (n >= 15) chk("tmo_bank_req", 64'(bank_flush_req_o), (n == 15) ? 64'h1 : 64'h0);
        end
        next_cycle(); flush_req_i = 1'b0;
        next_cycle();

        // Flush and bypass change together: bypass waits for RELEASE to end
        t0 = cyc; bank_mask_i = 4'b0011; flush_req_i = 1'b1; bypass_req_i = 1'b1;
        expect_ev(2'd1, 1'b0, t0 + 3);
        expect_ev(2'd3, 1'b0, t0 + 8);
        for (int n = 1; n <= 9; n++) begin
            next_cycle();
            bank_flush_ack_i = (n == 2) ? 4'b0011 : 4'b0000;
            if (n == 5) flush_req_i = 1'b0;
            if (n == 7) bank_bypass_ack_i = 4'b0011;
            @(negedge clk);
            if (n >= 3 && n <= 7) chk("byp_deferred", 64'(bypass_ack_o), 64'd0);
            if (n == 4) chk("combo_release", 64'(dut.state_q), 64'(ST_RELEASE));
        end

        // Async reset mid-command: requests drop at once, no ack follows
        next_cycle();
        bank_mask_i = 4'b0001; flush_req_i = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("pre_rst_req", 64'(bank_flush_req_o), 64'h1);
        next_cycle();
        rst_ni = 1'b0;
        #1;
        chk("async_rst_req", 64'({bank_flush_req_o, bank_bypass_req_o}), 64'd0);
        @(negedge clk);
        flush_req_i = 1'b0; bypass_req_i = 1'b0; bank_bypass_ack_i = 4'h0;
        next_cycle();
        rst_ni = 1'b1;
        repeat (3) next_cycle();

        // Statistics counters: table rows checked per cycle against the model
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < rows[r].reps; k++) begin
                bank_evt_i = rows[r].evt;
                ctrl_enable_regs_i = rows[r].en;
                ctrl_clear_regs_i = rows[r].clr;
                model_step(rows[r].evt, rows[r].en, rows[r].clr);
                next_cycle();
                x = cq.pop_front();
                chk("bank_count", bank_count_o, x.bank);
                chk("global_count", 64'(global_count_o), 64'(x.glob));
            end
            chk("row_bank1_hit", 64'(bank_count_o[16 +: 4]), 64'(rows[r].exp_b1));
            chk("row_global_hit", 64'(global_count_o[3:0]), 64'(rows[r].exp_g));
        end
        bank_evt_i = '0; ctrl_clear_regs_i = 1'b0;
        repeat (2) next_cycle();

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
